// File: rtl/reg16_serial_reader.sv
// Serializes one parallel word accepted over valid/ready onto sout with sframe/sdone strobes.
// Optional macro READER_PARITY_EN appends an even-parity bit after the data bits.
module reg16_serial_reader #(
  parameter int WIDTH     = 16,
  parameter int CLK_DIV   = 1,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sframe,
  output logic             sdone,
  output logic             busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);

`ifdef READER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_PAR   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [BIT_W-1:0] bit_q,   bit_d;
  logic             sout_q,   sout_d;
  logic             sframe_q, sframe_d;
  logic             sdone_q,  sdone_d;
  logic             busy_q,   busy_d;
  logic             ready_q,  ready_d;
`ifdef READER_PARITY_EN
  logic             par_q,    par_d;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
  endfunction

  // Next-state, shift register and divider/bit counter update
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
`ifdef READER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          state_d = ST_SHIFT;
          shreg_d = load_data;
          div_d   = DIV_ZERO;
          bit_d   = BIT_ZERO;
`ifdef READER_PARITY_EN
          par_d   = even_parity(load_data);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_MAX) begin
          div_d   = DIV_ZERO;
          shreg_d = advance(shreg_q);
          if (bit_q == BIT_MAX) begin
            bit_d = BIT_ZERO;
`ifdef READER_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_DONE;
`endif
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
`ifdef READER_PARITY_EN
      ST_PAR: begin
        if (div_q == DIV_MAX) begin
          div_d   = DIV_ZERO;
          state_d = ST_DONE;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered without extra latency
  always_comb begin
    sout_d   = 1'b0;
    sframe_d = 1'b0;
    sdone_d  = 1'b0;
    busy_d   = 1'b1;
    ready_d  = 1'b0;
    case (state_d)
      ST_IDLE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      ST_SHIFT: begin
        sout_d   = head_bit(shreg_d);
        sframe_d = 1'b1;
      end
`ifdef READER_PARITY_EN
      ST_PAR: begin
        sout_d   = par_d;
        sframe_d = 1'b1;
      end
`endif
      ST_DONE: begin
        sdone_d = 1'b1;
      end
      default: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= {WIDTH{1'b0}};
      div_q    <= DIV_ZERO;
      bit_q    <= BIT_ZERO;
      sout_q   <= 1'b0;
      sframe_q <= 1'b0;
      sdone_q  <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
`ifdef READER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sout_q   <= sout_d;
      sframe_q <= sframe_d;
      sdone_q  <= sdone_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
`ifdef READER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign sout       = sout_q;
  assign sframe     = sframe_q;
  assign sdone      = sdone_q;
  assign busy       = busy_q;
  assign load_ready = ready_q;

endmodule

// File: doc/reg16_serial_reader.md
Name: reg16_serial_reader

Overview:
- Read-side companion to the 16-bit operand/result registers of the fixed-point divider datapath.
- Accepts one parallel word over a valid/ready handshake, then shifts it out serially with frame and done strobes.
- Sits between the result register and the off-block debug/output pin path.
- Gives the team a narrow pin-level readout of divider results.

Parameters:
- WIDTH, 16, data word width in bits (minimum 2).
- CLK_DIV, 1, clock cycles each serial bit is held on sout (minimum 1).
- LSB_FIRST, 0, 0 = MSB shifted first; 1 = LSB shifted first.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  WIDTH  parallel word to serialize.
- load_ready  output  1  block can accept a word (high only in IDLE).
- sout  output  1  serial data bit.
- sframe  output  1  high while sout carries a data (or parity) bit.
- sdone  output  1  single-cycle pulse after the final bit.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - sout = 0, sframe = 0, sdone = 0, busy = 0, load_ready = 1.
  - Shift register and counters are cleared.
- Reset mid-transfer aborts the word immediately. After release the block is in IDLE and no sdone is issued.
- FSM states: IDLE, SHIFT, DONE (plus PAR when PARITY_EN is defined).
- IDLE:
  - load_ready = 1.
  - A transfer is accepted when load_valid = 1 at a rising edge. load_data is captured into the internal shift register and the state moves to SHIFT.
  - Without load_valid the block stays in IDLE; sout = 0.
- SHIFT:
  - sframe = 1, busy = 1, load_ready = 0.
  - sout presents the current bit: MSB first by default, LSB first when LSB_FIRST = 1.
  - Each bit is held exactly CLK_DIV cycles, timed by a divider counter that counts 0..CLK_DIV-1.
  - When the divider wraps, the shift register advances and a bit counter (0..WIDTH-1) increments.
  - When the divider wraps on bit WIDTH-1, the next state is DONE (or PAR).
  - Total SHIFT duration is exactly WIDTH*CLK_DIV cycles.
- Latency: the first bit appears on sout in the cycle after the accept edge.
- DONE:
  - Lasts exactly one cycle: sdone = 1, sframe = 0, sout = 0, busy = 1, load_ready = 0.
  - The next state is always IDLE.
- load_valid while busy is ignored. The word is not captured and no error is flagged; the upstream source must hold load_valid until load_ready.
- Back-to-back words: minimum spacing between accepts is WIDTH*CLK_DIV + 2 cycles (SHIFT + DONE + one IDLE cycle).
- load_data changes after the accept edge have no effect on the word being shifted.
- Counter widths are clog2-based. Both counters reset to 0 on every accept, so there is no carry-over between words.

Optional Feature:
- Macro name: READER_PARITY_EN.
- Defined:
  - After the last data bit the FSM enters PAR for CLK_DIV cycles, then DONE.
  - In PAR: sframe = 1 and sout = even parity (XOR of all WIDTH captured bits).
  - Total frame is (WIDTH+1)*CLK_DIV cycles.
- Not defined:
  - The PAR state and parity logic are absent; SHIFT goes directly to DONE.

Test Plan:
- Reset check: hold reset = 0 for 3 cycles with load_valid = 1 -> sout = 0, sframe = 0, sdone = 0, busy = 0, load_ready = 1; no capture occurs.
- Basic MSB-first transfer: CLK_DIV = 1, LSB_FIRST = 0, load 16'hA5C3 ->
  - sout over 16 cycles = 1010 0101 1100 0011;
  - sframe high for exactly 16 cycles;
  - sdone pulses once in cycle 17;
  - load_ready returns to 1 in cycle 18.
- LSB-first with divider: CLK_DIV = 3, LSB_FIRST = 1, load 16'h0001 -> sout = 1 for the first 3 cycles, then 0 for 45 cycles; sframe lasts 48 cycles; sdone pulses once.
- Busy rejection: during the 16'hA5C3 transfer, present load_valid = 1 with load_data = 16'hFFFF -> stream is unchanged; 16'hFFFF is not transmitted afterwards unless load_valid is still high in IDLE.
- Reset mid-transfer: assert reset = 0 after bit 7 of 16'hFFFF -> outputs go to reset values immediately; no sdone pulse; a new load of 16'h8000 after release streams correctly.
- Parity (READER_PARITY_EN defined): load 16'h0007 -> 16 data bits followed by parity bit sout = 1; sframe lasts 17 cycles; load 16'h0003 -> parity bit sout = 0.
